// File: rtl/i2c_slave_byte_ctl.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_byte_ctl
// Purpose  : Byte-level I2C slave controller. It synchronises and
//            glitch-filters SCL/SDA, detects START/STOP, matches a 7-bit
//            address, receives write bytes with optional ACK and transmits
//            read bytes. While it waits for read data it stretches SCL.
// Ports    : sysclk_i/reset_i  - clock, synchronous active-high reset
//            enable_i          - slave enable (0 forces idle, bus released)
//            slave_addr_i      - own 7-bit address (0 never matches)
//            dfsr_cnt_i        - filter sample interval in sysclk cycles
//            ack_en_i          - ACK received data bytes
//            tx_data_i/tx_valid_i/tx_ready_o - read-byte handshake
//            rx_data_o/rx_valid_o            - received byte + strobe
//            addr_match_o, rw_o, nack_o, stop_o, busy_o - status
//            scl_i/scl_o/scl_oen, sda_i/sda_o/sda_oen    - pads (oen=1 releases)
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_byte_ctl (
    input  logic        sysclk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic [6:0]  slave_addr_i,
    input  logic [15:0] dfsr_cnt_i,
    input  logic        ack_en_i,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    output logic        addr_match_o,
    output logic        rw_o,
    output logic        nack_o,
    output logic        stop_o,
    output logic        busy_o,
    input  logic        scl_i,
    output logic        scl_o,
    output logic        scl_oen,
    input  logic        sda_i,
    output logic        sda_o,
    output logic        sda_oen
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_RX       = 3'd3,
        S_RX_ACK   = 3'd4,
        S_TX_LOAD  = 3'd5,
        S_TX       = 3'd6,
        S_TX_ACK   = 3'd7
    } state_t;

    localparam logic [3:0] C_LAST_BIT = 4'd8;

    // ------------------------------------------------------------------
    // Synchronisers, sample divider and 3-sample majority-free filter
    // ------------------------------------------------------------------
    logic [1:0]  r_scl_sync;
    logic [1:0]  r_sda_sync;
    logic [15:0] r_div_cnt;
    logic [2:0]  r_scl_hist;
    logic [2:0]  r_sda_hist;
    logic        r_scl_filt;
    logic        r_sda_filt;
    logic        r_scl_prev;
    logic        r_sda_prev;

    logic [15:0] w_interval;
    logic        w_tick;
    logic [2:0]  w_scl_hist_nxt;
    logic [2:0]  w_sda_hist_nxt;

    // A zero interval behaves as one so the filter never stalls.
    assign w_interval     = (dfsr_cnt_i == 16'd0) ? 16'd1 : dfsr_cnt_i;
    // ">=" keeps the divider sane if the interval shrinks mid-count.
    assign w_tick         = (r_div_cnt >= (w_interval - 16'd1));
    assign w_scl_hist_nxt = {r_scl_hist[1:0], r_scl_sync[1]};
    assign w_sda_hist_nxt = {r_sda_hist[1:0], r_sda_sync[1]};

    always_ff @(posedge sysclk_i) begin
        if (reset_i) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_div_cnt  <= 16'd0;
            r_scl_hist <= 3'b111;
            r_sda_hist <= 3'b111;
            r_scl_filt <= 1'b1;
            r_sda_filt <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], scl_i};
            r_sda_sync <= {r_sda_sync[0], sda_i};
            r_div_cnt  <= w_tick ? 16'd0 : (r_div_cnt + 16'd1);
            if (w_tick) begin
                r_scl_hist <= w_scl_hist_nxt;
                r_sda_hist <= w_sda_hist_nxt;
                // Filtered level moves only when three samples agree.
                if (w_scl_hist_nxt == 3'b111)
                    r_scl_filt <= 1'b1;
                else if (w_scl_hist_nxt == 3'b000)
                    r_scl_filt <= 1'b0;
                if (w_sda_hist_nxt == 3'b111)
                    r_sda_filt <= 1'b1;
                else if (w_sda_hist_nxt == 3'b000)
                    r_sda_filt <= 1'b0;
            end
            r_scl_prev <= r_scl_filt;
            r_sda_prev <= r_sda_filt;
        end
    end

    logic w_scl_rise;
    logic w_scl_fall;
    logic w_sda_rise;
    logic w_sda_fall;
    logic w_start;
    logic w_stop;

    assign w_scl_rise = r_scl_filt & ~r_scl_prev;
    assign w_scl_fall = ~r_scl_filt & r_scl_prev;
    assign w_sda_rise = r_sda_filt & ~r_sda_prev;
    assign w_sda_fall = ~r_sda_filt & r_sda_prev;
    assign w_start    = w_sda_fall & r_scl_filt;
    assign w_stop     = w_sda_rise & r_scl_filt;

    // ------------------------------------------------------------------
    // Protocol FSM
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [6:0]  r_tx_sr;      // remaining read bits; bit7 goes straight to SDA
    logic        r_mack;       // master ACK bit sampled in TX_ACK
    logic        r_sda_oen;
    logic        r_scl_oen;
    logic [7:0]  r_rx_data;
    logic        r_rw;
    logic        r_busy;
    logic        r_rx_valid;
    logic        r_addr_match;
    logic        r_nack;
    logic        r_stop;

    state_t      w_state_nxt;
    logic [3:0]  w_bit_cnt_nxt;
    logic [7:0]  w_shift_nxt;
    logic [6:0]  w_tx_sr_nxt;
    logic        w_mack_nxt;
    logic        w_sda_oen_nxt;
    logic        w_scl_oen_nxt;
    logic [7:0]  w_rx_data_nxt;
    logic        w_rw_nxt;
    logic        w_busy_nxt;
    logic        w_rx_valid_nxt;
    logic        w_addr_match_nxt;
    logic        w_nack_nxt;
    logic        w_stop_nxt;
    logic [7:0]  w_rx_byte;

    assign w_rx_byte = {r_shift[6:0], r_sda_filt};

    always_ff @(posedge sysclk_i) begin
        if (reset_i) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= 4'd0;
            r_shift      <= 8'h00;
            r_tx_sr      <= 7'h00;
            r_mack       <= 1'b1;
            r_sda_oen    <= 1'b1;
            r_scl_oen    <= 1'b1;
            r_rx_data    <= 8'h00;
            r_rw         <= 1'b0;
            r_busy       <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_addr_match <= 1'b0;
            r_nack       <= 1'b0;
            r_stop       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_tx_sr      <= w_tx_sr_nxt;
            r_mack       <= w_mack_nxt;
            r_sda_oen    <= w_sda_oen_nxt;
            r_scl_oen    <= w_scl_oen_nxt;
            r_rx_data    <= w_rx_data_nxt;
            r_rw         <= w_rw_nxt;
            r_busy       <= w_busy_nxt;
            r_rx_valid   <= w_rx_valid_nxt;
            r_addr_match <= w_addr_match_nxt;
            r_nack       <= w_nack_nxt;
            r_stop       <= w_stop_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_shift_nxt      = r_shift;
        w_tx_sr_nxt      = r_tx_sr;
        w_mack_nxt       = r_mack;
        w_sda_oen_nxt    = r_sda_oen;
        w_scl_oen_nxt    = r_scl_oen;
        w_rx_data_nxt    = r_rx_data;
        w_rw_nxt         = r_rw;
        w_busy_nxt       = r_busy;
        w_rx_valid_nxt   = 1'b0;
        w_addr_match_nxt = 1'b0;
        w_nack_nxt       = 1'b0;
        w_stop_nxt       = 1'b0;

        if (!enable_i) begin
            w_state_nxt   = S_IDLE;
            w_bit_cnt_nxt = 4'd0;
            w_sda_oen_nxt = 1'b1;
            w_scl_oen_nxt = 1'b1;
            w_busy_nxt    = 1'b0;
        end else if (w_start) begin
            // START (including repeated START) wins over any SCL edge.
            w_state_nxt   = S_ADDR;
            w_bit_cnt_nxt = 4'd0;
            w_sda_oen_nxt = 1'b1;
            w_scl_oen_nxt = 1'b1;
            w_busy_nxt    = 1'b1;
        end else if (w_stop) begin
            w_state_nxt   = S_IDLE;
            w_bit_cnt_nxt = 4'd0;
            w_sda_oen_nxt = 1'b1;
            w_scl_oen_nxt = 1'b1;
            w_busy_nxt    = 1'b0;
            w_stop_nxt    = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_sda_oen_nxt = 1'b1;
                    w_scl_oen_nxt = 1'b1;
                end
                S_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_rx_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && (r_bit_cnt == C_LAST_BIT)) begin
                        w_bit_cnt_nxt = 4'd0;
                        if ((r_shift[7:1] == slave_addr_i) && (slave_addr_i != 7'd0)) begin
                            w_sda_oen_nxt    = 1'b0;
                            w_addr_match_nxt = 1'b1;
                            w_rw_nxt         = r_shift[0];
                            w_state_nxt      = S_ADDR_ACK;
                        end else begin
                            // Not for us: go quiet but the bus stays busy.
                            w_sda_oen_nxt = 1'b1;
                            w_state_nxt   = S_IDLE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_oen_nxt = 1'b1;
                        w_bit_cnt_nxt = 4'd0;
                        if (r_rw) begin
                            w_scl_oen_nxt = 1'b0;
                            w_state_nxt   = S_TX_LOAD;
                        end else begin
                            w_state_nxt   = S_RX;
                        end
                    end
                end
                S_RX: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_rx_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            w_rx_data_nxt  = w_rx_byte;
                            w_rx_valid_nxt = 1'b1;
                        end
                    end else if (w_scl_fall && (r_bit_cnt == C_LAST_BIT)) begin
                        w_sda_oen_nxt = ~ack_en_i;
                        w_bit_cnt_nxt = 4'd0;
                        w_state_nxt   = S_RX_ACK;
                    end
                end
                S_RX_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_oen_nxt = 1'b1;
                        w_bit_cnt_nxt = 4'd0;
                        w_state_nxt   = S_RX;
                    end
                end
                S_TX_LOAD: begin
                    // Stretch SCL until the read byte is supplied.
                    w_scl_oen_nxt = 1'b0;
                    if (tx_valid_i) begin
                        w_tx_sr_nxt   = tx_data_i[6:0];
                        w_sda_oen_nxt = tx_data_i[7];
                        w_bit_cnt_nxt = 4'd1;
                        w_state_nxt   = S_TX;
                    end
                end
                S_TX: begin
                    // SCL is released one cycle after bit7 appears on SDA.
                    if (!r_scl_oen)
                        w_scl_oen_nxt = 1'b1;
                    if (w_scl_fall) begin
                        if (r_bit_cnt == C_LAST_BIT) begin
                            w_sda_oen_nxt = 1'b1;
                            w_bit_cnt_nxt = 4'd0;
                            w_state_nxt   = S_TX_ACK;
                        end else begin
                            w_sda_oen_nxt = r_tx_sr[6];
                            w_tx_sr_nxt   = {r_tx_sr[5:0], 1'b0};
                            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        end
                    end
                end
                S_TX_ACK: begin
                    if (w_scl_rise) begin
                        w_mack_nxt = r_sda_filt;
                    end else if (w_scl_fall) begin
                        if (!r_mack) begin
                            w_scl_oen_nxt = 1'b0;
                            w_state_nxt   = S_TX_LOAD;
                        end else begin
                            w_nack_nxt    = 1'b1;
                            w_sda_oen_nxt = 1'b1;
                            w_scl_oen_nxt = 1'b1;
                            w_state_nxt   = S_IDLE;
                        end
                    end
                end
                default: begin
                    w_state_nxt   = S_IDLE;
                    w_sda_oen_nxt = 1'b1;
                    w_scl_oen_nxt = 1'b1;
                end
            endcase
        end
    end

    assign tx_ready_o   = (r_state == S_TX_LOAD);
    assign rx_data_o    = r_rx_data;
    assign rx_valid_o   = r_rx_valid;
    assign addr_match_o = r_addr_match;
    assign rw_o         = r_rw;
    assign nack_o       = r_nack;
    assign stop_o       = r_stop;
    assign busy_o       = r_busy;
    assign scl_o        = 1'b0;
    assign sda_o        = 1'b0;
    assign scl_oen      = r_scl_oen;
    assign sda_oen      = r_sda_oen;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_byte_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave_byte_ctl
// Purpose  : Directed self-checking bench for i2c_slave_byte_ctl. A
//            behavioural open-drain master drives the bus; expected values
//            are hand-computed constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_byte_ctl;

    localparam int C_Q   = 30;     // quarter SCL period in sysclk cycles
    localparam int C_TMO = 4000;   // bound on any wait for the DUT

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [6:0]  slave_addr;
    logic [15:0] dfsr;
    logic        ack_en;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        addr_match;
    logic        rw;
    logic        nack;
    logic        stop;
    logic        busy;
    logic        scl_o;
    logic        scl_oen;
    logic        sda_o;
    logic        sda_oen;
    logic        m_scl;
    logic        m_sda;
    logic        scl_bus;
    logic        sda_bus;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Wired-AND open-drain bus.
    assign scl_bus = m_scl & (scl_oen | scl_o);
    assign sda_bus = m_sda & (sda_oen | sda_o);

    i2c_slave_byte_ctl dut (
        .sysclk_i     (clk),
        .reset_i      (rst),
        .enable_i     (enable),
        .slave_addr_i (slave_addr),
        .dfsr_cnt_i   (dfsr),
        .ack_en_i     (ack_en),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready),
        .rx_data_o    (rx_data),
        .rx_valid_o   (rx_valid),
        .addr_match_o (addr_match),
        .rw_o         (rw),
        .nack_o       (nack),
        .stop_o       (stop),
        .busy_o       (busy),
        .scl_i        (scl_bus),
        .scl_o        (scl_o),
        .scl_oen      (scl_oen),
        .sda_i        (sda_bus),
        .sda_o        (sda_o),
        .sda_oen      (sda_oen)
    );

    // Event monitors (only ever read by the tests, which compare deltas).
    int   n_addr = 0, n_rxv = 0, n_stop = 0, n_nack = 0, n_rdy = 0;
    int   n_sda_drv = 0, n_viol = 0, n_long_str = 0, str_run = 0;
    logic prev_rdy = 1'b0, prev_scl_hi = 1'b0, prev_sda_oen = 1'b1;

    always @(negedge clk) begin
        if (addr_match === 1'b1) n_addr++;
        if (rx_valid === 1'b1) n_rxv++;
        if (stop === 1'b1) n_stop++;
        if (nack === 1'b1) n_nack++;
        if (tx_ready === 1'b1 && prev_rdy !== 1'b1) n_rdy++;
        if (sda_oen === 1'b0) n_sda_drv++;
        if (prev_scl_hi && scl_bus === 1'b1 && sda_oen !== prev_sda_oen) n_viol++;
        if (scl_oen === 1'b0) str_run++;
        else begin
            if (str_run >= 50) n_long_str++;
            str_run = 0;
        end
        prev_rdy     = tx_ready;
        prev_scl_hi  = (scl_bus === 1'b1);
        prev_sda_oen = sda_oen;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Master primitives
    // ------------------------------------------------------------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scl_release(output int waited);
        waited = 0;
        m_scl  = 1'b1;
        @(negedge clk);
        while (scl_bus !== 1'b1 && waited < C_TMO) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (scl_bus !== 1'b1) begin
            errors++;
            $display("FAIL scl_release: scl_bus=%b after %0d cycles, expected 1", scl_bus, waited);
        end
    endtask

    task automatic m_start();
        int w;
        m_sda = 1'b1;
        if (m_scl !== 1'b1) scl_release(w);
        wait_cyc(C_Q); m_sda = 1'b0;
        wait_cyc(C_Q); m_scl = 1'b0;
        wait_cyc(C_Q);
    endtask

    task automatic m_rstart();
        int w;
        m_sda = 1'b1;     wait_cyc(C_Q);
        scl_release(w);   wait_cyc(C_Q);
        m_sda = 1'b0;     wait_cyc(C_Q);
        m_scl = 1'b0;     wait_cyc(C_Q);
    endtask

    task automatic m_stop();
        int w;
        m_sda = 1'b0;     wait_cyc(C_Q);
        scl_release(w);   wait_cyc(C_Q);
        m_sda = 1'b1;     wait_cyc(C_Q);
    endtask

    task automatic m_write(input logic [7:0] b, output logic ack);
        int w;
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i];
            wait_cyc(C_Q); scl_release(w); wait_cyc(2 * C_Q);
            m_scl = 1'b0;  wait_cyc(C_Q);
        end
        m_sda = 1'b1;
        wait_cyc(C_Q); scl_release(w); wait_cyc(C_Q);
        ack = sda_bus;
        wait_cyc(C_Q);
        m_scl = 1'b0;  wait_cyc(C_Q);
    endtask

    task automatic m_read(input logic ack, output logic [7:0] b);
        int w;
        for (int i = 7; i >= 0; i--) begin
            wait_cyc(C_Q); scl_release(w); wait_cyc(C_Q);
            b[i] = sda_bus;
            wait_cyc(C_Q);
            m_scl = 1'b0;
            wait_cyc(C_Q);
        end
        m_sda = ack;
        wait_cyc(C_Q); scl_release(w); wait_cyc(2 * C_Q);
        m_scl = 1'b0;  wait_cyc(C_Q);
        m_sda = 1'b1;
    endtask

    // Application side of the read handshake.
    task automatic respond(input logic [7:0] d, input int dly);
        int n = 0;
        while (tx_ready !== 1'b1 && n < C_TMO) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL respond_ready: tx_ready=%b after %0d cycles, expected 1", tx_ready, n);
        end else begin
            repeat (dly) @(negedge clk);
            tx_data  = d;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        wait_cyc(4);
        rst = 1'b0;
        wait_cyc(1);
        checks++;
        if ({scl_oen, sda_oen, scl_o, sda_o} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_pads: {scl_oen,sda_oen,scl_o,sda_o}=%b expected 1100", {scl_oen, sda_oen, scl_o, sda_o});
        end
        checks++;
        if ({rx_data, rw, busy, tx_ready} !== 11'h000) begin
            errors++;
            $display("FAIL reset_regs: rx_data=%h rw=%b busy=%b tx_ready=%b expected 00 0 0 0", rx_data, rw, busy, tx_ready);
        end
        checks++;
        if ({rx_valid, addr_match, nack, stop} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pulses: %b expected 0000", {rx_valid, addr_match, nack, stop});
        end
    endtask

    task automatic test_glitch();
        int s0 = n_stop;
        m_sda = 1'b0; wait_cyc(6); m_sda = 1'b1;   // shorter than 3 samples at interval 4
        wait_cyc(100);
        checks++;
        if (busy !== 1'b0 || n_stop != s0) begin
            errors++;
            $display("FAIL glitch_reject: busy=%b stops=%0d expected 0 0", busy, n_stop - s0);
        end
        m_sda = 1'b0; wait_cyc(40);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_start: busy=%b expected 1", busy);
        end
        m_sda = 1'b1; wait_cyc(60);
        checks++;
        if (busy !== 1'b0 || n_stop - s0 != 1) begin
            errors++;
            $display("FAIL glitch_stop: busy=%b stops=%0d expected 0 1", busy, n_stop - s0);
        end
    endtask

    task automatic test_write();
        int   a0 = n_addr, r0 = n_rxv, s0 = n_stop, v0 = n_viol;
        logic k0, k1;
        m_start();
        m_write(8'hA0, k0);
        m_write(8'h3C, k1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL write_busy: busy=%b expected 1", busy);
        end
        m_stop();
        wait_cyc(50);
        checks++;
        if ({k0, k1} !== 2'b00) begin
            errors++;
            $display("FAIL write_acks: addr_ack=%b data_ack=%b expected 0 0", k0, k1);
        end
        checks++;
        if (n_addr - a0 != 1 || rw !== 1'b0) begin
            errors++;
            $display("FAIL write_addr: matches=%0d rw=%b expected 1 0", n_addr - a0, rw);
        end
        checks++;
        if (rx_data !== 8'h3C || n_rxv - r0 != 1) begin
            errors++;
            $display("FAIL write_data: rx_data=%h pulses=%0d expected 3c 1", rx_data, n_rxv - r0);
        end
        checks++;
        if (n_stop - s0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL write_stop: stops=%0d busy=%b expected 1 0", n_stop - s0, busy);
        end
        checks++;
        if (n_viol != v0) begin
            errors++;
            $display("FAIL write_sda_stable: %0d SDA changes with SCL high, expected 0", n_viol - v0);
        end
    endtask

    task automatic test_mismatch();
        int   a0 = n_addr, d0 = n_sda_drv, s0 = n_stop;
        logic k0, k1;
        m_start();
        m_write(8'hA2, k0);
        m_write(8'h55, k1);
        checks++;
        if (k0 !== 1'b1 || n_addr != a0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mismatch_addr: ack=%b matches=%0d busy=%b expected 1 0 1", k0, n_addr - a0, busy);
        end
        m_stop();
        wait_cyc(50);
        checks++;
        if (n_sda_drv != d0 || n_stop - s0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mismatch_quiet: sda_driven_cycles=%0d stops=%0d busy=%b expected 0 1 0",
                     n_sda_drv - d0, n_stop - s0, busy);
        end
    endtask

    task automatic test_no_ack();
        int   r0 = n_rxv;
        logic k0, k1;
        ack_en = 1'b0;
        m_start();
        m_write(8'hA0, k0);
        m_write(8'h81, k1);
        ack_en = 1'b1;
        m_stop();
        wait_cyc(50);
        checks++;
        if ({k0, k1} !== 2'b01) begin
            errors++;
            $display("FAIL noack_bits: addr_ack=%b data_ack=%b expected 0 1", k0, k1);
        end
        checks++;
        if (rx_data !== 8'h81 || n_rxv - r0 != 1) begin
            errors++;
            $display("FAIL noack_data: rx_data=%h pulses=%0d expected 81 1", rx_data, n_rxv - r0);
        end
    endtask

    task automatic test_read_stretch();
        int         y0 = n_rdy, l0 = n_long_str, n0 = n_nack, s0 = n_stop, v0 = n_viol;
        logic       k0;
        logic [7:0] b0, b1;
        fork
            begin
                m_start();
                m_write(8'hA1, k0);
                m_read(1'b0, b0);
                m_read(1'b1, b1);
                checks++;
                if (sda_oen !== 1'b1 || n_nack - n0 != 1) begin
                    errors++;
                    $display("FAIL read_nack: sda_oen=%b nacks=%0d expected 1 1", sda_oen, n_nack - n0);
                end
                m_stop();
            end
            begin
                respond(8'h96, 50);
                respond(8'h01, 3);
            end
        join
        wait_cyc(50);
        checks++;
        if (k0 !== 1'b0 || rw !== 1'b1) begin
            errors++;
            $display("FAIL read_addr: ack=%b rw=%b expected 0 1", k0, rw);
        end
        checks++;
        if (b0 !== 8'h96 || b1 !== 8'h01) begin
            errors++;
            $display("FAIL read_bytes: got %h %h expected 96 01", b0, b1);
        end
        checks++;
        if (n_rdy - y0 != 2 || n_long_str - l0 < 1) begin
            errors++;
            $display("FAIL read_stretch: ready_rises=%0d long_stretches=%0d expected 2 >=1", n_rdy - y0, n_long_str - l0);
        end
        checks++;
        if (n_stop - s0 != 1 || busy !== 1'b0 || tx_ready !== 1'b0 || n_viol != v0) begin
            errors++;
            $display("FAIL read_end: stops=%0d busy=%b tx_ready=%b viol=%0d expected 1 0 0 0",
                     n_stop - s0, busy, tx_ready, n_viol - v0);
        end
    endtask

    task automatic test_back_to_back();
        int         a0 = n_addr, r0 = n_rxv, s0 = n_stop;
        logic       k0, k1, k2;
        logic [7:0] b0;
        m_start();
        m_write(8'hA0, k0);
        m_write(8'h3C, k1);
        m_rstart();
        m_write(8'hA1, k2);
        checks++;
        if ({k0, k1, k2} !== 3'b000 || n_addr - a0 != 2 || rw !== 1'b1 || n_stop != s0) begin
            errors++;
            $display("FAIL rstart_addr: acks=%b matches=%0d rw=%b stops=%0d expected 000 2 1 0",
                     {k0, k1, k2}, n_addr - a0, rw, n_stop - s0);
        end
        fork
            respond(8'h5A, 2);
            m_read(1'b1, b0);
        join
        m_stop();
        wait_cyc(50);
        checks++;
        if (b0 !== 8'h5A || n_rxv - r0 != 1 || rx_data !== 8'h3C) begin
            errors++;
            $display("FAIL rstart_data: read=%h rx_pulses=%0d rx_data=%h expected 5a 1 3c", b0, n_rxv - r0, rx_data);
        end
    endtask

    task automatic test_enable();
        int   a0 = n_addr, s0 = n_stop;
        logic k0;
        enable = 1'b0;
        m_start();
        m_write(8'hA0, k0);
        checks++;
        if (k0 !== 1'b1 || busy !== 1'b0 || n_addr != a0) begin
            errors++;
            $display("FAIL disable_ack: ack=%b busy=%b matches=%0d expected 1 0 0", k0, busy, n_addr - a0);
        end
        m_stop();
        wait_cyc(50);
        checks++;
        if (n_stop != s0) begin
            errors++;
            $display("FAIL disable_stop: stops=%0d expected 0", n_stop - s0);
        end
        enable = 1'b1;
        wait_cyc(50);
    endtask

    task automatic test_dfsr_zero();
        int   a0 = n_addr;
        logic k0, k1;
        dfsr = 16'd0;
        wait_cyc(20);
        m_start();
        m_write(8'hA0, k0);
        m_write(8'hC5, k1);
        m_stop();
        wait_cyc(50);
        dfsr = 16'd4;
        checks++;
        if ({k0, k1} !== 2'b00 || n_addr - a0 != 1 || rx_data !== 8'hC5) begin
            errors++;
            $display("FAIL dfsr_zero: acks=%b matches=%0d rx_data=%h expected 00 1 c5", {k0, k1}, n_addr - a0, rx_data);
        end
    endtask

    task automatic test_reset_mid();
        int         w, s0;
        logic       k0;
        logic [2:0] bits;
        fork
            respond(8'hE7, 2);
            begin
                m_start();
                m_write(8'hA1, k0);
                for (int i = 2; i >= 0; i--) begin
                    wait_cyc(C_Q); scl_release(w); wait_cyc(C_Q);
                    bits[i] = sda_bus;
                    wait_cyc(C_Q); m_scl = 1'b0; wait_cyc(C_Q);
                end
                wait_cyc(C_Q); scl_release(w); wait_cyc(C_Q);   // inside bit 4 (a 0)
            end
        join
        checks++;
        if (bits !== 3'b111 || sda_oen !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_pre: bits=%b sda_oen=%b expected 111 0", bits, sda_oen);
        end
        s0  = n_stop;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({scl_oen, sda_oen, scl_o, sda_o} !== 4'b1100) begin
            errors++;
            $display("FAIL rstmid_pads: {scl_oen,sda_oen,scl_o,sda_o}=%b expected 1100", {scl_oen, sda_oen, scl_o, sda_o});
        end
        checks++;
        if ({rx_data, rw, busy, tx_ready, rx_valid, addr_match, nack, stop} !== 15'h0000) begin
            errors++;
            $display("FAIL rstmid_regs: rx_data=%h rw=%b busy=%b tx_ready=%b pulses=%b expected 00 0 0 0 0000",
                     rx_data, rw, busy, tx_ready, {rx_valid, addr_match, nack, stop});
        end
        wait_cyc(200);
        checks++;
        if (n_stop != s0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_quiet: stops=%0d busy=%b expected 0 0", n_stop - s0, busy);
        end
    endtask

    initial begin
        rst        = 1'b1;
        enable     = 1'b1;
        slave_addr = 7'h50;
        dfsr       = 16'd4;
        ack_en     = 1'b1;
        tx_data    = 8'h00;
        tx_valid   = 1'b0;
        m_scl      = 1'b1;
        m_sda      = 1'b1;

        test_reset();
        test_glitch();
        test_write();
        test_mismatch();
        test_no_ack();
        test_read_stretch();
        test_back_to_back();
        test_enable();
        test_dfsr_zero();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_slave_byte_ctl.md
I2C_SLAVE_BYTE_CTL -- requirements
Module: i2c_slave_byte_ctl

Interface
REQ-001 SHALL have one clock and one reset: sysclk_i in 1, system clock; reset_i in 1, synchronous active-high reset.
REQ-002 SHALL have these control inputs:
- enable_i in 1: slave enable.
- slave_addr_i in 7: own 7-bit address.
- dfsr_cnt_i in 16: filter sample interval, in sysclk cycles.
- ack_en_i in 1: ACK received data bytes.
REQ-003 SHALL have the transmit handshake: tx_data_i in 8, read byte for the master; tx_valid_i in 1; tx_ready_o out 1, byte requested.
REQ-004 SHALL have the receive outputs: rx_data_o out 8, last received byte; rx_valid_o out 1, one-cycle pulse.
REQ-005 SHALL have these status outputs:
- addr_match_o out 1: one-cycle pulse.
- rw_o out 1: R/W bit of last matched address.
- nack_o out 1: one-cycle pulse, master NACKed a read byte.
- stop_o out 1: one-cycle pulse.
- busy_o out 1: bus busy.
REQ-006 SHALL have the pad signals, using the codebase iobuf convention:
- scl_i in 1; scl_o out 1; scl_oen out 1.
- sda_i in 1; sda_o out 1; sda_oen out 1.
- oen=1 releases the line; scl_o and sda_o are constant 0.

Function
REQ-007 SHALL pass scl_i and sda_i through 2-FF synchronizers.
REQ-008 SHALL sample the synchronized lines once every max(dfsr_cnt_i,1) sysclk cycles.
REQ-009 SHALL update each filtered line only when 3 consecutive samples agree.
REQ-010 SHALL derive SCL rise/fall and SDA rise/fall as one-cycle strobes from the filtered lines only.
REQ-011 SHALL detect START as filtered SDA falling while filtered SCL is high; START enters ADDR from any state (repeated START included), sets busy_o and clears the bit counter.
REQ-012 SHALL detect STOP as filtered SDA rising while filtered SCL is high; STOP enters IDLE from any state, pulses stop_o, clears busy_o and releases SDA/SCL.
REQ-013 SHALL implement the states IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX_LOAD, TX, TX_ACK.
REQ-014 In ADDR, SHALL shift SDA in MSB first on each SCL rise.
REQ-015 SHALL complete address-byte handling on the 8th SCL fall:
- If byte[7:1]==slave_addr_i and slave_addr_i!=0: drive SDA low; pulse addr_match_o; latch rw_o=byte[0]; enter ADDR_ACK.
- Otherwise: enter IDLE with lines released; busy_o stays set.
REQ-016 On the SCL fall ending ADDR_ACK, SHALL release SDA and enter RX (rw_o=0) or TX_LOAD (rw_o=1).
REQ-017 In RX, SHALL shift SDA in on each SCL rise; on the 8th rise it updates rx_data_o and pulses rx_valid_o for exactly one cycle.
REQ-018 On the 8th SCL fall in RX, SHALL drive SDA low if ack_en_i=1, otherwise release it; then enter RX_ACK.
REQ-019 On the SCL fall ending RX_ACK, SHALL release SDA and return to RX.
REQ-020 In TX_LOAD, SHALL assert tx_ready_o and hold SCL low (scl_oen=0, clock stretch) until tx_valid_i&tx_ready_o.
REQ-021 On the accept cycle, SHALL latch tx_data_i, drive bit7 on SDA, release SCL on the following cycle, and enter TX.
REQ-022 In TX, SHALL drive the next bit on each SCL fall; on the 8th fall it releases SDA and enters TX_ACK.
REQ-023 In TX_ACK, SHALL sample SDA on the SCL rise and act on the following SCL fall:
- ACK (0): enter TX_LOAD.
- NACK (1): pulse nack_o; enter IDLE with lines released.
REQ-024 Data SHALL be driven as 1 by releasing SDA and as 0 by pulling it low; SDA SHALL never change while filtered SCL is high, except on START/STOP detection.
REQ-025 When enable_i=0, SHALL force IDLE, release both lines, suppress all pulses and hold busy_o=0.
REQ-026 SHALL give START/STOP priority over every same-cycle SCL edge.
REQ-027 tx_ready_o SHALL be asserted only in TX_LOAD.

Reset
REQ-028 On reset_i=1 at a sysclk edge, SHALL enter IDLE.
REQ-029 SHALL reset outputs as follows:
- scl_oen=1, sda_oen=1, scl_o=0, sda_o=0.
- rx_data_o=8'h00, rw_o=0, busy_o=0.
- tx_ready_o=0 and all pulses 0.
REQ-030 SHALL clear the filter and synchronizers to 1 on reset.
REQ-031 Reset mid-transfer SHALL release the bus within one cycle, with no spurious START/STOP afterwards.

Verification
REQ-032 Write: slave_addr_i=7'h50, dfsr_cnt_i=4, ack_en_i=1; master sends START, 0xA0, 0x3C, STOP -> addr_match_o pulses once with rw_o=0; ACK on both 9th clocks; rx_data_o=0x3C with one rx_valid_o pulse; stop_o pulses; busy_o returns to 0.
REQ-033 Address mismatch: master sends 0xA2 -> no ACK, no addr_match_o, SDA never driven until STOP.
REQ-034 Read with stretch: master sends 0xA1; tx_valid_i is held off 50 cycles after tx_ready_o -> SCL is held low 50+ cycles; 0x96 is sent MSB first after accept; master ACK -> tx_ready_o reasserts; second byte 0x01; master NACK -> nack_o pulses, SDA released.
REQ-035 Repeated START: write 0x3C, then START and 0xA1 without STOP -> ADDR is re-entered, rw_o=1, and TX_LOAD is reached.
REQ-036 ack_en_i=0 during a write byte -> SDA released on the 9th clock and rx_valid_o still pulses.
REQ-037 reset_i asserted during the 4th bit of a read byte -> scl_oen=sda_oen=1 next cycle, and all outputs match REQ-029.
